// File: rtl/ed25519_pkg.sv
// Shared field constants, operation encodings and scheduler state type
// for the GF(2^255-19) point-arithmetic datapath.
package ed25519_pkg;

    localparam int FE_W = 256;

    localparam logic [FE_W-1:0] P_25519 =
        256'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFED;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } sched_state_t;

endpackage

// File: rtl/fe25519_addsub.sv
// Combinational modular add/sub over GF(2^255-19); operands must already be
// reduced (< P), the result is then reduced as well.
module fe25519_addsub
    import ed25519_pkg::*;
(
    input  logic [FE_W-1:0] a,
    input  logic [FE_W-1:0] b,
    input  logic            op,
    output logic [FE_W-1:0] res
);

    logic [FE_W:0]   sum;
    logic [FE_W:0]   diff;
    logic [FE_W-1:0] sum_red;
    logic [FE_W-1:0] diff_fix;

    // Corrections are done modulo 2^FE_W: the true value always fits in FE_W bits.
    always_comb begin
        sum      = {1'b0, a} + {1'b0, b};
        diff     = {1'b0, a} - {1'b0, b};
        sum_red  = sum[FE_W-1:0] - P_25519;
        diff_fix = diff[FE_W-1:0] + P_25519;
        res      = '0;
        if (op == OP_ADD) begin
            res = (sum >= {1'b0, P_25519}) ? sum_red : sum[FE_W-1:0];
        end else begin
            res = diff[FE_W] ? diff_fix : diff[FE_W-1:0];
        end
    end

endmodule

// File: rtl/rr_arbiter_n.sv
// Combinational round-robin arbiter: searches last+1, last+2, ... mod N and
// returns the first requesting index as both one-hot and binary.
module rr_arbiter_n #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    int cand;

    // NOTE: every output gets a default before the search loop so no path leaves
    // a value unassigned; that is what keeps this block free of inferred latches.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        for (int k = 1; k <= N; k++) begin
            cand = (int'(last) + k) % N;
            if (!any && req[IW'(cand)]) begin
                any               = 1'b1;
                idx               = IW'(cand);
                grant[IW'(cand)]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/addsub25519_rr_sched.sv
// Round-robin scheduler sharing one GF(2^255-19) add/sub unit among NUM_REQ
// requesters. Define ADDSUB_SCHED_STATS_EN to add the ops_cnt statistics port.
module addsub25519_rr_sched
    import ed25519_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int W       = FE_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*W-1:0] req_a,
    input  logic [NUM_REQ*W-1:0] req_b,
    input  logic [NUM_REQ-1:0]   req_op,
    output logic [NUM_REQ-1:0]   rsp_valid,
    input  logic [NUM_REQ-1:0]   rsp_ready,
    output logic [W-1:0]         rsp_res,
    output logic                 busy
`ifdef ADDSUB_SCHED_STATS_EN
    ,
    output logic [31:0]          ops_cnt
`endif
);

    localparam int IW = $clog2(NUM_REQ);

    sched_state_t   state;
    sched_state_t   state_nxt;
    logic [IW-1:0]  rr_ptr;
    logic [IW-1:0]  gidx;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic           op_q;
    logic [W-1:0]   unit_res;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IW-1:0]      arb_idx;
    logic               arb_any;
    logic               accept;
    logic               rsp_hs;

    logic [W-1:0] a_arr [NUM_REQ];
    logic [W-1:0] b_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*W +: W];
        assign b_arr[i] = req_b[i*W +: W];
    end

    rr_arbiter_n #(
        .N (NUM_REQ)
    ) u_arb (
        .req   (req_valid),
        .last  (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    fe25519_addsub u_addsub (
        .a   (a_q),
        .b   (b_q),
        .op  (op_q),
        .res (unit_res)
    );

    // Handshakes and next state; req_ready is the arbiter grant exposed only in IDLE.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        rsp_hs    = 1'b0;
        req_ready = '0;
        rsp_valid = '0;
        case (state)
            IDLE: begin
                if (!rst) begin
                    req_ready = arb_grant;
                end
                if (arb_any) begin
                    accept    = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = RESP;
            end
            RESP: begin
                rsp_valid[gidx] = 1'b1;
                if (rsp_ready[gidx]) begin
                    rsp_hs    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rr_ptr  <= IW'(NUM_REQ - 1);
            gidx    <= '0;
            rsp_res <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                rr_ptr <= arb_idx;
                gidx   <= arb_idx;
            end
            if (state == EXEC) begin
                rsp_res <= unit_res;
            end
        end
    end

    // NOTE: operand registers carry no reset: they are always loaded on accept
    // before EXEC reads them, so a reset would only cost wiring on 513 flops.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q  <= a_arr[arb_idx];
            b_q  <= b_arr[arb_idx];
            op_q <= req_op[arb_idx];
        end
    end

`ifdef ADDSUB_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ops_cnt <= '0;
        end else if (rsp_hs && (ops_cnt != 32'hFFFF_FFFF)) begin
            ops_cnt <= ops_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_addsub25519_rr_sched.sv
// Self-checking bench for addsub25519_rr_sched: directed steps plus a scoreboard
// fed at request handshakes and drained at response handshakes.
module tb_addsub25519_rr_sched;

    localparam int N  = 4;
    localparam int FW = 256;
    localparam logic [FW-1:0] P =
        256'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFED;
    localparam logic [FW-1:0] P_M1 =
        256'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFEC;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*FW-1:0] req_a = '0;
    logic [N*FW-1:0] req_b = '0;
    logic [N-1:0]    req_op = '0;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready = '1;
    logic [FW-1:0]   rsp_res;
    logic            busy;
`ifdef ADDSUB_SCHED_STATS_EN
    logic [31:0]     ops_cnt;
`endif

    typedef struct {
        int            idx;
        logic [FW-1:0] res;
    } exp_t;

    exp_t sb[$];
    int   grant_log[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    addsub25519_rr_sched #(.NUM_REQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_res   (rsp_res),
        .busy      (busy)
`ifdef ADDSUB_SCHED_STATS_EN
        ,
        .ops_cnt   (ops_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [FW-1:0] model(input logic [FW-1:0] a, input logic [FW-1:0] b,
                                            input logic op);
        logic [511:0] t;
        if (!op) t = (512'(a) + 512'(b)) % 512'(P);
        else     t = (512'(a) + 512'(P) - 512'(b)) % 512'(P);
        return t[FW-1:0];
    endfunction

    task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input int idx, input logic [FW-1:0] a, input logic [FW-1:0] b,
                           input logic op);
        req_a[idx*FW +: FW] = a;
        req_b[idx*FW +: FW] = b;
        req_op[idx]         = op;
        req_valid[idx]      = 1'b1;
    endtask

    task automatic wait_ready(input int idx);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            #1;
            if (req_ready[idx]) ok = 1'b1;
            else tick();
        end
        check("req_ready_wait", FW'(ok), FW'(1));
    endtask

    task automatic wait_rsp(input int idx, output logic [FW-1:0] res);
        bit ok;
        ok  = 1'b0;
        res = '0;
        for (int k = 0; k < 20 && !ok; k++) begin
            #1;
            if (rsp_valid[idx] && rsp_ready[idx]) begin
                ok  = 1'b1;
                res = rsp_res;
            end else begin
                tick();
            end
        end
        check("rsp_valid_wait", FW'(ok), FW'(1));
        tick();
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 30 && !ok; k++) begin
            #1;
            if (!busy) ok = 1'b1;
            else tick();
        end
        check("idle_wait", FW'(ok), FW'(1));
    endtask

    task automatic run_op(input int idx, input logic [FW-1:0] a, input logic [FW-1:0] b,
                          input logic op, output logic [FW-1:0] res);
        set_req(idx, a, b, op);
        wait_ready(idx);
        tick();
        req_valid[idx] = 1'b0;
        wait_rsp(idx, res);
    endtask

    // Scoreboard monitor, sampling well after the bench drives on the falling edge.
    always begin
        exp_t e;
        @(negedge clk);
        #4;
        if (rst !== 1'b1) begin
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    e.idx = i;
                    e.res = model(req_a[i*FW +: FW], req_b[i*FW +: FW], req_op[i]);
                    sb.push_back(e);
                    grant_log.push_back(i);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (rsp_valid[i] && rsp_ready[i]) begin
                    if (sb.size() == 0) begin
                        check("sb_underflow", FW'(1), FW'(0));
                    end else begin
                        e = sb.pop_front();
                        check("rsp_idx", FW'(i), FW'(e.idx));
                        check("rsp_res", rsp_res, e.res);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [FW-1:0] r;

        // Reset values
        tick();
        tick();
        #1;
        check("rst_req_ready", FW'(req_ready), FW'(0));
        check("rst_rsp_valid", FW'(rsp_valid), FW'(0));
        check("rst_rsp_res", rsp_res, '0);
        check("rst_busy", FW'(busy), FW'(0));
`ifdef ADDSUB_SCHED_STATS_EN
        check("rst_ops_cnt", FW'(ops_cnt), FW'(0));
`endif
        tick();
        rst = 1'b0;

        // Single add P-1 + 1 with exact latency
        set_req(0, P_M1, 256'd1, 1'b0);
        #1;
        check("t1_ready_T", FW'(req_ready), FW'(4'b0001));
        tick();
        req_valid[0] = 1'b0;
        #1;
        check("t1_exec_ready", FW'(req_ready), FW'(0));
        check("t1_exec_rsp_valid", FW'(rsp_valid), FW'(0));
        check("t1_exec_busy", FW'(busy), FW'(1));
        tick();
        #1;
        check("t1_rsp_valid_T2", FW'(rsp_valid), FW'(4'b0001));
        check("t1_rsp_res", rsp_res, '0);
        tick();
        #1;
        check("t1_idle_busy", FW'(busy), FW'(0));
        check("t1_idle_rsp_valid", FW'(rsp_valid), FW'(0));
        tick();

        // Subtraction wrap and equal operands
        run_op(1, 256'd0, 256'd1, 1'b1, r);
        check("t2_sub_wrap", r, P_M1);
        run_op(1, 256'd5, 256'd5, 1'b1, r);
        check("t2_sub_equal", r, '0);

        // All four valid right after reset: grant order 0,1,2,3,0
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        sb.delete();
        grant_log.delete();
        set_req(0, P - 256'd2, 256'd5, 1'b0);
        set_req(1, 256'd100, 256'd200, 1'b0);
        set_req(2, 256'd3, 256'd10, 1'b1);
        set_req(3, P_M1, P_M1, 1'b0);
        repeat (13) tick();
        req_valid = '0;
        wait_idle();
        tick();
        check("t3_grant_count", FW'(grant_log.size()), FW'(5));
        if (grant_log.size() == 5) begin
            check("t3_grant0", FW'(grant_log[0]), FW'(0));
            check("t3_grant1", FW'(grant_log[1]), FW'(1));
            check("t3_grant2", FW'(grant_log[2]), FW'(2));
            check("t3_grant3", FW'(grant_log[3]), FW'(3));
            check("t3_grant4", FW'(grant_log[4]), FW'(0));
        end

        // Response back-pressure: hold for 10 cycles with another request pending
        rsp_ready = 4'b1011;
        set_req(2, 256'd10, 256'd3, 1'b1);
        wait_ready(2);
        check("t4_ready_onehot", FW'(req_ready), FW'(4'b0100));
        tick();
        req_valid[2] = 1'b0;
        set_req(0, 256'd7, 256'd9, 1'b0);
        tick();
        for (int k = 0; k < 10; k++) begin
            #1;
            check("t4_hold_rsp_valid", FW'(rsp_valid), FW'(4'b0100));
            check("t4_hold_rsp_res", rsp_res, 256'd7);
            check("t4_hold_req_ready", FW'(req_ready), FW'(0));
            check("t4_hold_busy", FW'(busy), FW'(1));
            tick();
        end
        rsp_ready = '1;
        tick();
        #1;
        check("t4_next_grant", FW'(req_ready), FW'(4'b0001));
        tick();
        req_valid[0] = 1'b0;
        wait_rsp(0, r);
        check("t4_req0_res", r, 256'd16);

        // Reset while an op is in EXEC
        set_req(3, 256'd40, 256'd2, 1'b0);
        wait_ready(3);
        tick();
        req_valid[3] = 1'b0;
        rst = 1'b1;
        set_req(1, 256'd11, 256'd22, 1'b0);
        set_req(2, 256'd0, 256'd5, 1'b1);
        tick();
        #1;
        check("t5_rst_rsp_valid", FW'(rsp_valid), FW'(0));
        check("t5_rst_busy", FW'(busy), FW'(0));
        check("t5_rst_rsp_res", rsp_res, '0);
        check("t5_rst_req_ready", FW'(req_ready), FW'(0));
        sb.delete();
        rst = 1'b0;
        #1;
        check("t5_first_grant", FW'(req_ready), FW'(4'b0010));
        tick();
        req_valid[1] = 1'b0;
        wait_rsp(1, r);
        check("t5_req1_res", r, 256'd33);
        wait_ready(2);
        tick();
        req_valid[2] = 1'b0;
        wait_rsp(2, r);
        check("t5_req2_res", r, P - 256'd5);

`ifdef ADDSUB_SCHED_STATS_EN
        // Two ops done since the last reset; five more make seven
        for (int k = 0; k < 5; k++) begin
            run_op(k % N, 256'(k + 1), 256'(k * 3), 1'b0, r);
        end
        #1;
        check("t6_ops_cnt_7", FW'(ops_cnt), FW'(7));
        force dut.ops_cnt = 32'hFFFF_FFFF;
        tick();
        release dut.ops_cnt;
        run_op(2, 256'd1, 256'd1, 1'b0, r);
        #1;
        check("t6_ops_cnt_sat", FW'(ops_cnt), FW'(32'hFFFF_FFFF));
`endif

        tick();
        check("sb_empty", FW'(sb.size()), FW'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
